// File: rtl/board_load_sequencer_pkg.sv
// Shared encodings for the board load sequencer and the wrapper bench.
// Target codes pick which loader strobe fires once a word is assembled.
package board_load_sequencer_pkg;

   localparam logic [1:0] TGT_DATA  = 2'b00;
   localparam logic [1:0] TGT_NUM   = 2'b01;
   localparam logic [1:0] TGT_OP    = 2'b10;
   localparam logic [1:0] TGT_CARRY = 2'b11;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_ISSUE   = 1'b1
   } state_t;

   // Returns {Carry_Flag, OP, Num, Data} loader enables for a target code.
   function automatic logic [3:0] loader_sel(input logic [1:0] tgt);
      logic [3:0] sel;
      sel = 4'b0000;
      unique case (1'b1)
         (tgt == TGT_DATA):  sel = 4'b0001;
         (tgt == TGT_NUM):   sel = 4'b0010;
         (tgt == TGT_OP):    sel = 4'b0100;
         (tgt == TGT_CARRY): sel = 4'b1000;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/board_load_sequencer_debouncer.sv
// Push-button conditioner: two-flop synchroniser, stable-level counter
// and a single-cycle press pulse on the debounced rising edge.
module button_debouncer
   import board_load_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic press
);

   localparam int CW =
      (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic          level;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          settled;

   assign differ  = (sync2 != level);
   assign settled = differ && (cnt == LAST);

   // Fires in the cycle whose closing edge raises the level,
   // so consumers act on the same edge the level flips.
   assign press = settled && sync2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         level <= 1'b0;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         if (!differ) begin
            cnt <= '0;
         end else if (settled) begin
            cnt   <= '0;
            level <= sync2;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/board_load_sequencer.sv
// Assembles a 32-bit word from four switch bytes, MSB first, then
// strobes the selected wrapper loader for PULSE_CYCLES cycles.
module board_load_sequencer
   import board_load_sequencer_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int PULSE_CYCLES    = 4
) (
   input  logic        CP,
   input  logic        reset,
   input  logic [7:0]  sw,
   input  logic [1:0]  target,
   input  logic        btn,
   input  logic        btn_clr,
   output logic [31:0] data,
   output logic        Data_loader,
   output logic        Num_loader,
   output logic        OP_loader,
   output logic        Carry_Flag_loader,
   output logic        busy,
   output logic [1:0]  byte_idx,
   output logic        done
);

   localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);

   state_t      state;
   state_t      state_n;
   logic [31:0] shadow;
   logic [31:0] shadow_n;
   logic [31:0] data_q;
   logic [31:0] data_n;
   logic [1:0]  idx;
   logic [1:0]  idx_n;
   logic [1:0]  tgt;
   logic [1:0]  tgt_n;
   logic [3:0]  pcnt;
   logic [3:0]  pcnt_n;
   logic        done_q;
   logic        done_n;
   logic        btn_press;
   logic        clr_press;

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_btn (
      .clk   (CP),
      .rst_n (reset),
      .raw   (btn),
      .press (btn_press)
   );

   button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_clr (
      .clk   (CP),
      .rst_n (reset),
      .raw   (btn_clr),
      .press (clr_press)
   );

   always_ff @(posedge CP or negedge reset) begin
      if (!reset) begin
         state  <= ST_COLLECT;
         shadow <= '0;
         data_q <= '0;
         idx    <= '0;
         tgt    <= TGT_DATA;
         pcnt   <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_n;
         shadow <= shadow_n;
         data_q <= data_n;
         idx    <= idx_n;
         tgt    <= tgt_n;
         pcnt   <= pcnt_n;
         done_q <= done_n;
      end
   end

   always_comb begin
      state_n  = state;
      shadow_n = shadow;
      data_n   = data_q;
      idx_n    = idx;
      tgt_n    = tgt;
      pcnt_n   = pcnt;
      done_n   = 1'b0;
      unique case (state)
         ST_COLLECT: begin
            // Clear dominates a simultaneous byte press.
            if (clr_press) begin
               shadow_n = '0;
               idx_n    = '0;
            end else if (btn_press) begin
               unique case (idx)
                  2'd0: shadow_n[31:24] = sw;
                  2'd1: shadow_n[23:16] = sw;
                  2'd2: shadow_n[15:8]  = sw;
                  2'd3: shadow_n[7:0]   = sw;
               endcase
               idx_n = idx + 2'd1;
               if (idx == 2'd3) begin
                  tgt_n   = target;
                  data_n  = shadow_n;
                  pcnt_n  = '0;
                  state_n = ST_ISSUE;
               end
            end
         end
         ST_ISSUE: begin
            if (pcnt == PULSE_LAST) begin
               pcnt_n  = '0;
               done_n  = 1'b1;
               state_n = ST_COLLECT;
            end else begin
               pcnt_n = pcnt + 4'd1;
            end
         end
      endcase
   end

   assign busy     = (state == ST_ISSUE);
   assign data     = data_q;
   assign byte_idx = idx;
   assign done     = done_q;

   assign {Carry_Flag_loader, OP_loader, Num_loader, Data_loader} =
      busy ? loader_sel(tgt) : 4'b0000;

endmodule

// File: tb/tb_board_load_sequencer.sv
// Scoreboard bench: each assembled word is queued when its bytes are
// driven and compared when the sequencer raises its strobe.
module tb_board_load_sequencer;

   typedef struct packed {
      logic [31:0] word;
      logic [1:0]  tgt;
   } exp_t;

   logic        CP = 1'b0;
   logic        reset;
   logic        rst_long;
   logic [7:0]  sw;
   logic [1:0]  target;
   logic        btn;
   logic        btn_clr;

   logic [31:0] data;
   logic        Data_loader, Num_loader, OP_loader, Carry_Flag_loader;
   logic        busy, done;
   logic [1:0]  byte_idx;
   logic [3:0]  ld;

   logic [31:0] l_data;
   logic [3:0]  l_ld;
   logic        l_busy, l_done;
   logic [1:0]  l_idx;

   int   errors = 0;
   int   checks = 0;
   int   issue_cnt = 0;
   int   done_cnt = 0;
   int   len = 0;
   logic busy_q = 1'b0;
   exp_t sb[$];
   exp_t cur;

   assign ld = {Carry_Flag_loader, OP_loader, Num_loader, Data_loader};

   board_load_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .PULSE_CYCLES(4)
   ) dut (
      .CP                (CP),
      .reset             (reset),
      .sw                (sw),
      .target            (target),
      .btn               (btn),
      .btn_clr           (btn_clr),
      .data              (data),
      .Data_loader       (Data_loader),
      .Num_loader        (Num_loader),
      .OP_loader         (OP_loader),
      .Carry_Flag_loader (Carry_Flag_loader),
      .busy              (busy),
      .byte_idx          (byte_idx),
      .done              (done)
   );

   // Long strobe makes a press landing inside ISSUE reachable.
   board_load_sequencer #(
      .DEBOUNCE_CYCLES(4),
      .PULSE_CYCLES(15)
   ) dut_long (
      .CP                (CP),
      .reset             (rst_long),
      .sw                (sw),
      .target            (target),
      .btn               (btn),
      .btn_clr           (btn_clr),
      .data              (l_data),
      .Data_loader       (l_ld[0]),
      .Num_loader        (l_ld[1]),
      .OP_loader         (l_ld[2]),
      .Carry_Flag_loader (l_ld[3]),
      .busy              (l_busy),
      .byte_idx          (l_idx),
      .done              (l_done)
   );

   always #5 CP = ~CP;

   a_onehot: assert property (@(posedge CP) $onehot0(ld));

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CP);
      #1;
   endtask

   task automatic press(input logic [7:0] b, input int hold = 10,
                        input int gap = 10);
      sw  = b;
      btn = 1'b1;
      tick(hold);
      btn = 1'b0;
      tick(gap);
   endtask

   task automatic clr_press();
      btn_clr = 1'b1;
      tick(10);
      btn_clr = 1'b0;
      tick(10);
   endtask

   task automatic expect_word(input logic [1:0] t, input logic [31:0] w);
      exp_t e;
      e.word = w;
      e.tgt  = t;
      sb.push_back(e);
   endtask

   task automatic load(input logic [1:0] t, input logic [31:0] w);
      target = t;
      expect_word(t, w);
      press(w[31:24]);
      check("idx_b0", byte_idx, 1);
      press(w[23:16]);
      check("idx_b1", byte_idx, 2);
      press(w[15:8]);
      check("idx_b2", byte_idx, 3);
      press(w[7:0]);
      check("idx_wrap", byte_idx, 0);
   endtask

   always @(negedge CP) begin
      if (busy && !busy_q) begin
         issue_cnt++;
         len = 1;
         if (sb.size() == 0) begin
            check("unexpected_issue", 1, 0);
         end else begin
            cur = sb.pop_front();
            check("issue_data", data, cur.word);
            check("issue_loader", ld, 4'b0001 << cur.tgt);
         end
      end else if (busy) begin
         len++;
         check("hold_data", data, cur.word);
         check("hold_loader", ld, 4'b0001 << cur.tgt);
      end else if (busy_q && reset) begin
         check("strobe_len", len, 4);
         check("done_pulse", done, 1);
      end
      if (done) done_cnt++;
      busy_q = busy;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      int saved;
      reset = 1'b1;
      rst_long = 1'b1;
      sw = 8'h00;
      target = 2'b00;
      btn = 1'b0;
      btn_clr = 1'b0;
      #1;
      reset = 1'b0;
      rst_long = 1'b0;

      repeat (5) begin
         @(negedge CP);
         check("reset_state", {data, ld, busy, done, byte_idx}, 0);
      end
      @(posedge CP);
      #1;
      reset = 1'b1;
      repeat (20) begin
         @(negedge CP);
         check("idle_state", {data, ld, busy, done, byte_idx}, 0);
      end
      tick(1);

      // Target is only sampled on the fourth press.
      target = 2'b01;
      press(8'h70);
      check("dl_idx1", byte_idx, 1);
      press(8'h02);
      check("dl_idx2", byte_idx, 2);
      press(8'h04);
      check("dl_idx3", byte_idx, 3);
      target = 2'b00;
      expect_word(2'b00, 32'h70020402);
      press(8'h02);
      check("dl_idx0", byte_idx, 0);
      check("dl_issues", issue_cnt, 1);
      check("dl_dones", done_cnt, 1);
      check("dl_data_held", data, 32'h70020402);

      load(2'b10, 32'h00000001);

      btn = 1'b1;
      tick(2);
      btn = 1'b0;
      tick(10);
      check("glitch_idx", byte_idx, 0);
      sw = 8'hA5;
      btn = 1'b1;
      tick(5);
      check("bounce_early", byte_idx, 0);
      tick(1);
      check("bounce_edge", byte_idx, 1);
      tick(4);
      btn = 1'b0;
      tick(10);
      check("bounce_once", byte_idx, 1);

      press(8'h5A);
      check("clr_pre_idx", byte_idx, 2);
      clr_press();
      check("clr_idx", byte_idx, 0);
      check("clr_data_kept", data, 32'h00000001);
      load(2'b11, 32'h11223344);

      press(8'h01);
      press(8'h02);
      press(8'h03);
      check("both_pre_idx", byte_idx, 3);
      saved = issue_cnt;
      btn = 1'b1;
      btn_clr = 1'b1;
      tick(10);
      btn = 1'b0;
      btn_clr = 1'b0;
      tick(10);
      check("both_idx3", byte_idx, 0);
      check("both_no_issue", issue_cnt, saved);
      btn = 1'b1;
      btn_clr = 1'b1;
      tick(10);
      btn = 1'b0;
      btn_clr = 1'b0;
      tick(10);
      check("both_idx0", byte_idx, 0);

      load(2'b01, 32'h00000000);
      check("num_data", data, 0);

      rst_long = 1'b1;
      tick(2);
      target = 2'b10;
      expect_word(2'b10, 32'hAABBCCDD);
      press(8'hAA);
      press(8'hBB);
      press(8'hCC);
      press(8'hDD, 5, 5);
      sw = 8'hEE;
      btn = 1'b1;
      tick(6);
      check("long_in_issue", l_busy, 1);
      check("long_idx_hold", l_idx, 0);
      check("main_took_byte", byte_idx, 1);
      tick(4);
      btn = 1'b0;
      tick(20);
      check("long_idx_after", l_idx, 0);
      check("long_data", l_data, 32'hAABBCCDD);
      check("long_idle", l_busy, 0);
      rst_long = 1'b0;
      clr_press();
      check("post_long_idx", byte_idx, 0);

      target = 2'b00;
      expect_word(2'b00, 32'h12345678);
      press(8'h12);
      press(8'h34);
      press(8'h56);
      sw = 8'h78;
      btn = 1'b1;
      n = 0;
      while (!busy && n < 20) begin
         tick(1);
         n++;
      end
      check("issue_start", busy, 1);
      tick(1);
      reset = 1'b0;
      btn = 1'b0;
      #1;
      check("rst_loaders", ld, 0);
      check("rst_busy", busy, 0);
      check("rst_data", data, 0);
      tick(3);
      reset = 1'b1;
      tick(3);
      check("post_rst", {data, ld, busy, done, byte_idx}, 0);
      load(2'b01, 32'h0A0B0C0D);

      check("sb_empty", sb.size(), 0);
      check("issue_total", issue_cnt, 7);
      check("done_total", done_cnt, 6);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
